// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake, 1-entry decode skid buffer, redirect.
// Optional macro FETCH_CNT_EN enables the delivered-instruction counter on fetch_cnt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [15:0] id_imm,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IMM_W = 16;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_nxt;
  logic [XLEN-1:0]   r_tgt;
  logic [XLEN-1:0]   w_tgt_nxt;
  logic              r_id_valid;
  logic              w_id_valid_nxt;
  logic [XLEN-1:0]   r_id_instr;
  logic [XLEN-1:0]   w_id_instr_nxt;
  logic [XLEN-1:0]   r_id_pc4;
  logic [XLEN-1:0]   w_id_pc4_nxt;
  logic [XLEN-1:0]   r_skid_instr;
  logic [XLEN-1:0]   w_skid_instr_nxt;
  logic [XLEN-1:0]   r_skid_pc4;
  logic [XLEN-1:0]   w_skid_pc4_nxt;
  logic [XLEN-1:0]   w_redir_pc;
  logic [XLEN-1:0]   w_pc_plus4;

  // Low target bits are forced to zero so every fetch stays word aligned.
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_tgt_nxt        = r_tgt;
    w_id_valid_nxt   = r_id_valid;
    w_id_instr_nxt   = r_id_instr;
    w_id_pc4_nxt     = r_id_pc4;
    w_skid_instr_nxt = r_skid_instr;
    w_skid_pc4_nxt   = r_skid_pc4;

    // Decode took the current word and nothing new arrives unless a case below says so.
    if (!stall) begin
      w_id_valid_nxt = 1'b0;
    end

    unique case (r_state)
      S_FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_tgt_nxt   = w_redir_pc;
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_ack) begin
          w_pc_nxt = w_pc_plus4;
          if (!r_id_valid || !stall) begin
            w_id_valid_nxt = 1'b1;
            w_id_instr_nxt = imem_rdata;
            w_id_pc4_nxt   = w_pc_plus4;
          end else begin
            w_skid_instr_nxt = imem_rdata;
            w_skid_pc4_nxt   = w_pc_plus4;
            w_state_nxt      = S_HOLD;
          end
        end
      end

      S_DRAIN: begin
        // The outstanding word belongs to the old path; it is consumed and dropped.
        if (redirect) begin
          w_tgt_nxt = w_redir_pc;
        end
        if (imem_ack) begin
          w_pc_nxt    = redirect ? w_redir_pc : r_tgt;
          w_state_nxt = S_FETCH;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          w_skid_instr_nxt = '0;
          w_skid_pc4_nxt   = '0;
          w_pc_nxt         = w_redir_pc;
          w_state_nxt      = S_FETCH;
        end else if (!stall) begin
          w_id_valid_nxt = 1'b1;
          w_id_instr_nxt = r_skid_instr;
          w_id_pc4_nxt   = r_skid_pc4;
          w_state_nxt    = S_FETCH;
        end
      end

      default: begin
        w_state_nxt = S_FETCH;
      end
    endcase

    if (redirect) begin
      w_id_valid_nxt = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_tgt        <= '0;
      r_id_valid   <= 1'b0;
      r_id_instr   <= '0;
      r_id_pc4     <= '0;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_tgt        <= w_tgt_nxt;
      r_id_valid   <= w_id_valid_nxt;
      r_id_instr   <= w_id_instr_nxt;
      r_id_pc4     <= w_id_pc4_nxt;
      r_skid_instr <= w_skid_instr_nxt;
      r_skid_pc4   <= w_skid_pc4_nxt;
    end
  end

`ifdef FETCH_CNT_EN
  logic [XLEN-1:0] r_fetch_cnt;

  // Counts words actually taken by decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
    end else if (r_id_valid && !stall && !redirect) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
`else
  assign fetch_cnt = 32'h0;
`endif

  assign imem_req  = (r_state != S_HOLD);
  assign imem_addr = r_pc;
  assign id_valid  = r_id_valid;
  assign id_instr  = r_id_instr;
  assign id_pc4    = r_id_pc4;
  assign id_imm    = r_id_instr[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency imem, random stall/redirect, stream-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [15:0] id_imm;
  logic [31:0] fetch_cnt;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc4     (id_pc4),
    .id_imm     (id_imm),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: odd multiplier keeps every address distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Memory model state
  int wcnt    = 0;
  int cur_lat = 0;
  int lat_cfg = 0;

  function automatic int pick_lat();
    return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
  endfunction

  task automatic set_lat(input int l);
    lat_cfg = l;
    cur_lat = pick_lat();
  endtask

  // Reference model: the in-order stream of words decode must receive.
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;
  bit          flush_pend;
  int          consumed;

  task automatic model_reset();
    exp_pc     = RESET_PC;
    exp_cnt    = 32'h0;
    flush_pend = 1'b0;
    wcnt       = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    if (flush_pend) chk("flush_after_redirect", 32'(id_valid), 32'h0);
    flush_pend = 1'b0;
`ifdef FETCH_CNT_EN
    chk("fetch_cnt", fetch_cnt, exp_cnt);
`else
    chk("fetch_cnt_tied", fetch_cnt, 32'h0);
`endif
    if (redirect) begin
      exp_pc     = redirect_pc & 32'hFFFF_FFFC;
      flush_pend = 1'b1;
    end else if (id_valid && !stall) begin
      w = mem_word(exp_pc);
      chk("id_instr", id_instr, w);
      chk("id_pc4", id_pc4, exp_pc + 32'd4);
      chk("id_imm", 32'(id_imm), {16'h0, w[15:0]});
      exp_pc   = exp_pc + 32'd4;
      exp_cnt  = exp_cnt + 32'd1;
      consumed++;
    end
  endtask

  // One clock: memory responds, inputs driven, outputs checked at the falling edge.
  // rmode: 0 none, 1 redirect, 2 redirect only if no ack, 3 redirect only with ack.
  task automatic cycle(input bit st, input int rmode, input logic [31:0] rpc,
                       output bit did_ack, output bit did_redir);
    @(posedge clk);
    #1;
    did_ack = 1'b0;
    if (imem_req) begin
      if (wcnt >= cur_lat) begin
        did_ack = 1'b1;
        wcnt    = 0;
        cur_lat = pick_lat();
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    imem_ack   = did_ack;
    imem_rdata = did_ack ? mem_word(imem_addr) : $urandom;
    did_redir  = (rmode == 1) || (rmode == 2 && !did_ack) || (rmode == 3 && did_ack);
    stall       = st;
    redirect    = did_redir;
    redirect_pc = did_redir ? rpc : $urandom;
    @(negedge clk);
    model_step();
  endtask

  initial begin
    bit a, r, found;
    int pulses;
    int base;
    logic [31:0] rpc;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    model_reset();
    consumed = 0;
    set_lat(0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_pc4", id_pc4, 32'h0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    rst = 1'b0;

    // Zero-wait memory, no stall: id_pc4 = 4, 8, C, 10
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 0, 32'h0, a, r);
      if (k == 1) chk("req_after_reset", 32'(imem_req), 32'h1);
      else begin
        chk("seq_valid", 32'(id_valid), 32'h1);
        chk("seq_pc4", id_pc4, 32'(4 * (k - 1)));
      end
    end

    // Three wait states: one id_valid pulse per four cycles
    set_lat(3);
    repeat (8) cycle(1'b0, 0, 32'h0, a, r);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b0, 0, 32'h0, a, r);
      if (id_valid) pulses++;
    end
    chk("lat3_pulses", 32'(pulses), 32'd3);

    // Stall two cycles with ack: second word parks in the skid, request drops
    set_lat(0);
    repeat (3) cycle(1'b0, 0, 32'h0, a, r);
    cycle(1'b1, 0, 32'h0, a, r);
    cycle(1'b1, 0, 32'h0, a, r);
    chk("hold_req_low", 32'(imem_req), 32'h0);
    chk("hold_valid", 32'(id_valid), 32'h1);
    repeat (6) cycle(1'b0, 0, 32'h0, a, r);

    // Redirect while a request is outstanding: drain, then fetch 0x100
    set_lat(3);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, 2, 32'h100, a, r);
      found = r;
    end
    chk("drain_redirect_seen", 32'(found), 32'h1);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, 0, 32'h0, a, r);
      chk("drain_no_valid", 32'(id_valid), 32'h0);
      found = a;
    end
    chk("drain_ack_seen", 32'(found), 32'h1);
    cycle(1'b0, 0, 32'h0, a, r);
    chk("drain_next_addr", imem_addr, 32'h100);
    base = consumed;
    repeat (6) cycle(1'b0, 0, 32'h0, a, r);
    chk("drain_target_delivered", 32'(consumed > base), 32'h1);

    // Redirect and ack in the same cycle
    set_lat(0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, 3, 32'h202, a, r);
      found = r;
    end
    chk("redir_ack_seen", 32'(found), 32'h1);
    cycle(1'b0, 0, 32'h0, a, r);
    chk("redir_ack_addr", imem_addr, 32'h200);
    repeat (4) cycle(1'b0, 0, 32'h0, a, r);

    // Random traffic
    set_lat(-1);
    base = consumed;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else rpc = $urandom & 32'h0000_FFFF;
      cycle($urandom_range(0, 99) < 30, ($urandom_range(0, 99) < 5) ? 1 : 0, rpc, a, r);
    end
    chk("random_liveness", 32'(consumed - base >= 300), 32'h1);

    // Asynchronous reset in the middle of a drain
    set_lat(3);
    repeat (4) cycle(1'b0, 0, 32'h0, a, r);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, 2, 32'h440, a, r);
      found = r;
    end
    chk("rst_drain_redirect_seen", 32'(found), 32'h1);
    @(posedge clk);
    #2;
    redirect = 1'b0;
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_imem_addr", imem_addr, RESET_PC);
    chk("arst_id_valid", 32'(id_valid), 32'h0);
    chk("arst_fetch_cnt", fetch_cnt, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // PC wrap: fetch at 0xFFFFFFFC delivers id_pc4 = 0
    set_lat(0);
    cycle(1'b0, 1, 32'hFFFF_FFFC, a, r);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cycle(1'b0, 0, 32'h0, a, r);
      if (id_valid) begin
        chk("wrap_pc4", id_pc4, 32'h0);
        found = 1'b1;
      end
    end
    chk("wrap_seen", 32'(found), 32'h1);
    repeat (4) cycle(1'b0, 0, 32'h0, a, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
